// File: rtl/seven_segment_source_scheduler_if.sv
// Requester bundle and display-side outputs of the seven-segment source scheduler.
// The master drives requests and hold; the slave (the scheduler) returns grant and display data.
interface seven_segment_source_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC*32-1:0] req_value;
    logic                  hold;
    logic [NUM_SRC-1:0]    grant;
    logic [31:0]           value;
    logic [2:0]            active_src;
    logic                  display_valid;

    modport master (
        output req, req_value, hold,
        input  grant, value, active_src, display_valid
    );

    modport slave (
        input  req, req_value, hold,
        output grant, value, active_src, display_valid
    );
endinterface

// File: rtl/seven_segment_source_scheduler.sv
// Round-robin time-slot scheduler that picks which requester's 32-bit value is shown on the display.
// Each granted source holds the display for exactly DWELL cycles; hold freezes the running slot.
module seven_segment_source_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int DWELL   = 50000
) (
    input logic clk,
    input logic rst,
    seven_segment_source_scheduler_if.slave bus
);
    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     counter_reg, counter_next;
    logic [2:0]           last_reg, last_next;
    logic [31:0]          value_reg, value_next;
    logic [2:0]           active_reg, active_next;
    logic [NUM_SRC-1:0]   grant_reg, grant_next;
    logic                 valid_reg, valid_next;

    logic [31:0]          src_val [NUM_SRC];
    logic [2:0]           winner;
    logic                 capture;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_val[gi] = bus.req_value[32*gi +: 32];
    end

    // Round-robin: scan from the source after the last winner, wrapping around.
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_reg) + k) % NUM_SRC;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        last_next    = last_reg;
        value_next   = value_reg;
        active_next  = active_reg;
        grant_next   = '0;
        valid_next   = valid_reg;
        capture      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|bus.req) capture = 1'b1;
            end
            SHOW: begin
                // An expired slot keeps re-arbitrating every cycle until someone asks.
                if (!bus.hold) begin
                    if (counter_reg != '0)
                        counter_next = counter_reg - 1'b1;
                    else if (|bus.req)
                        capture = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (capture) begin
            state_next   = SHOW;
            value_next   = src_val[winner];
            active_next  = winner;
            grant_next   = NUM_SRC'(1) << winner;
            counter_next = CNT_W'(DWELL - 1);
            last_next    = winner;
            valid_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            last_reg    <= 3'(NUM_SRC - 1);
            value_reg   <= '0;
            active_reg  <= '0;
            grant_reg   <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            last_reg    <= last_next;
            value_reg   <= value_next;
            active_reg  <= active_next;
            grant_reg   <= grant_next;
            valid_reg   <= valid_next;
        end
    end

    assign bus.grant         = grant_reg;
    assign bus.value         = value_reg;
    assign bus.active_src    = active_reg;
    assign bus.display_valid = valid_reg;
endmodule

// File: tb/tb_seven_segment_source_scheduler.sv
// Randomized bench for the seven-segment source scheduler against a slot-accounting reference model.
module tb_seven_segment_source_scheduler;
    localparam int N     = 4;
    localparam int DWELL = 4;

    logic clk;
    logic rst;

    seven_segment_source_scheduler_if #(.NUM_SRC(N)) bus ();

    seven_segment_source_scheduler #(.NUM_SRC(N), .DWELL(DWELL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a slot is over once DWELL un-held edges have passed since its grant.
    logic [N-1:0] m_grant;
    logic [31:0]  m_value;
    logic [2:0]   m_active;
    logic         m_valid;
    int           m_last;
    int           m_elapsed;
    bit           m_shown;
    int           cyc;

    task automatic model_reset();
        m_grant = '0; m_value = '0; m_active = '0; m_valid = 1'b0;
        m_last = N - 1; m_elapsed = 0; m_shown = 1'b0;
    endtask

    task automatic step();
        bit eligible;
        bit found;
        int i;
        m_grant = '0;
        if (!m_shown) eligible = 1'b1;
        else if (bus.hold) eligible = 1'b0;
        else begin
            m_elapsed++;
            eligible = (m_elapsed >= DWELL);
        end
        found = 1'b0;
        if (eligible && bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (!found && bus.req[i]) begin
                    found     = 1'b1;
                    m_value   = bus.req_value[32*i +: 32];
                    m_active  = 3'(i);
                    m_grant   = N'(1) << i;
                    m_last    = i;
                    m_valid   = 1'b1;
                    m_shown   = 1'b1;
                    m_elapsed = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.hold = 1'b0; bus.req_value = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic randomize_values();
        bus.req_value = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({bus.grant, bus.value, bus.display_valid} !== {4'b0, 32'h0, 1'b0})
                $display("FAIL reset cyc=%0d got grant=%b value=%h valid=%b, want all zero",
                         cyc, bus.grant, bus.value, bus.display_valid);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        randomize_values();
        bus.req_value[31:0] = 32'h12345678;
        for (int c = 0; c < 13; c++) begin
            step();
            randomize_values();
            n_checks++;
            if ({bus.grant, bus.value, bus.active_src, bus.display_valid} !==
                {m_grant, m_value, m_active, m_valid})
                $display("FAIL single cyc=%0d got g=%b v=%h s=%0d dv=%b, want g=%b v=%h s=%0d dv=%b",
                         cyc, bus.grant, bus.value, bus.active_src, bus.display_valid,
                         m_grant, m_value, m_active, m_valid);
            else n_pass++;
            // Regrants land on cycles 1, 5, 9, 13 after reset.
            if ((cyc % DWELL) == 1) begin
                n_checks++;
                if (bus.grant !== 4'b0001)
                    $display("FAIL single_regrant cyc=%0d got grant=%b want 0001", cyc, bus.grant);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_order [5];
        int got = 0;
        int last_cyc = 0;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 20 && got < 5; c++) begin
            randomize_values();
            step();
            n_checks++;
            if ({bus.grant, bus.value, bus.active_src} !== {m_grant, m_value, m_active})
                $display("FAIL rr_model cyc=%0d got g=%b v=%h s=%0d, want g=%b v=%h s=%0d",
                         cyc, bus.grant, bus.value, bus.active_src, m_grant, m_value, m_active);
            else n_pass++;
            if (bus.grant != '0) begin
                n_checks++;
                if (bus.grant !== exp_order[got] || (got > 0 && cyc - last_cyc != DWELL))
                    $display("FAIL rr_order idx=%0d got grant=%b gap=%0d, want grant=%b gap=%0d",
                             got, bus.grant, cyc - last_cyc, exp_order[got], DWELL);
                else n_pass++;
                last_cyc = cyc;
                got++;
            end
        end
        n_checks++;
        if (got != 5) $display("FAIL rr_count got %0d grants, want 5", got);
        else n_pass++;
    endtask

    task automatic test_hold();
        int budget = 0;
        do_reset();
        bus.req = 4'b1111;
        randomize_values();
        while (bus.grant !== 4'b0010 && budget < 20) begin
            step();
            budget++;
        end
        n_checks++;
        if (bus.grant !== 4'b0010) $display("FAIL hold_setup got grant=%b want 0010", bus.grant);
        else n_pass++;
        step();
        for (int c = 0; c < 18; c++) begin
            bus.hold = (c < 10);
            randomize_values();
            step();
            n_checks++;
            if ({bus.grant, bus.value, bus.active_src} !== {m_grant, m_value, m_active})
                $display("FAIL hold cyc=%0d hold=%b got g=%b v=%h s=%0d, want g=%b v=%h s=%0d",
                         cyc, bus.hold, bus.grant, bus.value, bus.active_src,
                         m_grant, m_value, m_active);
            else n_pass++;
        end
        bus.hold = 1'b0;
    endtask

    task automatic test_starvation();
        logic [31:0] held;
        do_reset();
        bus.req = 4'b0010;
        randomize_values();
        step();
        held = bus.req_value[63:32];
        for (int c = 0; c < DWELL - 1; c++) step();
        bus.req = '0;
        for (int c = 0; c < 6; c++) begin
            randomize_values();
            step();
            n_checks++;
            if ({bus.grant, bus.value, bus.active_src} !== {4'b0000, held, 3'd1})
                $display("FAIL starve_hold cyc=%0d got g=%b v=%h s=%0d, want g=0000 v=%h s=1",
                         cyc, bus.grant, bus.value, bus.active_src, held);
            else n_pass++;
        end
        bus.req = 4'b0100;
        randomize_values();
        held = bus.req_value[95:64];
        step();
        n_checks++;
        if ({bus.grant, bus.value, bus.active_src} !== {4'b0100, held, 3'd2})
            $display("FAIL starve_resume got g=%b v=%h s=%0d, want g=0100 v=%h s=2",
                     bus.grant, bus.value, bus.active_src, held);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [N-1:0] r;
        int lowest;
        do_reset();
        bus.req = 4'b1111;
        randomize_values();
        for (int c = 0; c < 6; c++) step();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.grant, bus.value, bus.active_src, bus.display_valid} !== '0)
            $display("FAIL async_reset got g=%b v=%h s=%0d dv=%b, want all zero",
                     bus.grant, bus.value, bus.active_src, bus.display_valid);
        else n_pass++;
        #1 rst = 1'b0;
        model_reset();
        r = 4'($urandom_range(1, 15));
        bus.req = r;
        lowest = 0;
        for (int i = N - 1; i >= 0; i--) if (r[i]) lowest = i;
        step();
        n_checks++;
        if (bus.grant !== (N'(1) << lowest) || bus.active_src !== 3'(lowest))
            $display("FAIL async_regrant req=%b got g=%b s=%0d, want g=%b s=%0d",
                     r, bus.grant, bus.active_src, N'(1) << lowest, lowest);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            bus.req  = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
            bus.hold = ($urandom_range(0, 5) == 0);
            randomize_values();
            step();
            n_checks++;
            if ({bus.grant, bus.value, bus.active_src, bus.display_valid} !==
                {m_grant, m_value, m_active, m_valid})
                $display("FAIL random cyc=%0d got g=%b v=%h s=%0d dv=%b, want g=%b v=%h s=%0d dv=%b",
                         cyc, bus.grant, bus.value, bus.active_src, bus.display_valid,
                         m_grant, m_value, m_active, m_valid);
            else n_pass++;
        end
        bus.hold = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.hold = 1'b0; bus.req_value = '0;
        cyc = 0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_starvation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seven_segment_source_scheduler.md
SEVEN_SEGMENT_SOURCE_SCHEDULER -- requirements
Module: seven_segment_source_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_SRC, 4, number of requesters (2..8).
  DWELL, 50000, display cycles per slot (>=2).
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  req  input  NUM_SRC  bit i high = source i wants display time.
  req_value  input  NUM_SRC*32  packed values; source i at bits [32i+31:32i].
  hold  input  1  freeze current slot (no dwell count, no re-arbitration).
  grant  output  NUM_SRC  one-hot, one-cycle pulse on the cycle source value is captured.
  value  output  32  value driven to the display controller.
  active_src  output  3  index of the source currently shown.
  display_valid  output  1  high once any value has been captured.
REQ-003 The block SHALL use clk as its only clock and rst as asynchronous, active-high reset.

Function
REQ-004 FSM SHALL have two states: IDLE (nothing shown yet), SHOW (slot running or expired).
REQ-005 IDLE: if no req bit is set, the block SHALL stay in IDLE with all outputs at reset values.
REQ-006 IDLE with any req set: the block SHALL, on that clock edge, arbitrate, capture the winner's req_value into value, set active_src, pulse grant, load dwell counter to DWELL-1 and enter SHOW.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_SRC and picks the first set req bit.
REQ-008 The only requesting source SHALL be re-granted repeatedly.
REQ-009 After reset, last_granted SHALL be NUM_SRC-1, so source 0 has top priority.
REQ-010 SHOW with hold=0 and counter>0: counter SHALL decrement by 1 per cycle.
REQ-011 Counter at 0 with hold=0 and any req set: the block SHALL arbitrate and capture as in REQ-006. The next slot starts the following cycle. Slot length is exactly DWELL cycles.
REQ-012 Counter at 0 with no req set: the block SHALL stay in SHOW with counter at 0 and value, active_src unchanged. It SHALL re-arbitrate on each cycle until a req appears.
REQ-013 hold=1 SHALL freeze the counter and block all arbitration and capture, including when the counter is 0. Outputs SHALL hold unchanged.
REQ-014 value SHALL change only on a grant cycle.
REQ-015 Deasserting req or changing req_value mid-slot SHALL NOT affect the displayed value.
REQ-016 grant SHALL be exactly one-hot on a capture cycle and all-zero otherwise.
REQ-017 display_valid SHALL rise with the first grant and stay high until reset.
REQ-018 active_src SHALL be zero-extended to 3 bits.
REQ-019 All outputs SHALL be registered. There is no combinational path from req, req_value or hold to any output.

Reset
REQ-020 While rst=1, the block SHALL drive: state IDLE, value=0, active_src=0, grant=0, display_valid=0, counter=0, last_granted=NUM_SRC-1.
REQ-021 rst asserted mid-slot SHALL clear all of REQ-020 immediately, without waiting for a clock edge.
REQ-022 The first arbitration after rst deasserts SHALL follow REQ-009.

Verification (DWELL=4, NUM_SRC=4)
REQ-023 Bench SHALL cover, at minimum:
- Reset: req=0 after reset -> value=0, display_valid=0, grant=0 for 10 cycles.
- Single source: req=0001, value0=0x12345678 -> grant=0001 at edge 1; value=0x12345678; re-grant every 4 cycles.
- Round-robin: req=1111 -> grant order 0001,0010,0100,1000,0001, spaced 4 cycles; active_src 0,1,2,3,0.
- Hold: assert hold during the slot of source 1 for 10 cycles -> no grant; value unchanged; slot resumes with remaining count after release.
- Starvation end: req drops to 0 at slot end -> value held; req=0100 later -> grant=0100 on the next edge.
- Async reset mid-slot: rst pulsed between edges -> outputs zero without a clock edge; next grant goes to the lowest set req.
